// File: rtl/aes_round_controller.sv
// rtl/aes_round_controller.sv - AES-128 round sequencer: state register, round counter, round-key handshake
module aes_round_controller #(
  parameter int NUM_ROUNDS = 10,
  parameter int RW         = $clog2(NUM_ROUNDS + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [0:15][7:0]     data_in,
  output logic                 busy,
  output logic                 done,
  output logic [0:15][7:0]     data_out,
  output logic                 key_req,
  output logic [RW-1:0]        key_round,
  input  logic                 key_valid,
  input  logic [0:3][31:0]     round_key,
  output logic [0:15][7:0]     round_in,
  output logic                 final_round,
  input  logic [0:15][7:0]     round_out,
  output logic [0:15][7:0]     rk_state,
  output logic [0:3][31:0]     rk_key,
  input  logic [0:15][7:0]     rk_result
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS);

  state_t          state, state_nxt;
  logic [RW-1:0]   round, round_nxt;
  logic [0:15][7:0] state_reg, state_reg_nxt;
  logic [0:15][7:0] data_out_reg, data_out_nxt;

  // State, round counter, cipher state and result registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      round        <= '0;
      state_reg    <= '0;
      data_out_reg <= '0;
    end else begin
      state        <= state_nxt;
      round        <= round_nxt;
      state_reg    <= state_reg_nxt;
      data_out_reg <= data_out_nxt;
    end
  end

  // Next-state logic: abort beats key_valid, a round only advances on an accepted key
  always_comb begin
    state_nxt     = state;
    round_nxt     = round;
    state_reg_nxt = state_reg;
    data_out_nxt  = data_out_reg;
    case (state)
      IDLE: begin
        if (start) begin
          state_reg_nxt = data_in;
          round_nxt     = '0;
          state_nxt     = REQ;
        end
      end
      REQ: begin
        if (abort) begin
          round_nxt = '0;
          state_nxt = IDLE;
        end else if (key_valid) begin
          state_reg_nxt = rk_result;
          if (round == LAST_ROUND) begin
            data_out_nxt = rk_result;
            state_nxt    = DONE;
          end else begin
            round_nxt = round + RW'(1);
          end
        end
      end
      DONE: begin
        round_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        round_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only; round 0 keys the raw plaintext
  always_comb begin
    busy        = (state == REQ) || (state == DONE);
    done        = (state == DONE);
    key_req     = (state == REQ);
    key_round   = round;
    final_round = (round == LAST_ROUND);
    data_out    = data_out_reg;
    round_in    = state_reg;
    rk_state    = (round == '0) ? state_reg : round_out;
    rk_key      = round_key;
  end

endmodule

// File: tb/tb_aes_round_controller.sv
// tb/tb_aes_round_controller.sv - directed bench for aes_round_controller with a reference AES datapath
module tb_aes_round_controller;

  localparam int NR = 10;
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] STUB_CT = {16{8'h01}};

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [0:9][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic             clk, n_rst, start, abort, key_valid;
  logic [0:15][7:0] data_in, data_out, round_in, round_out, rk_state, rk_result;
  logic [0:3][31:0] round_key, rk_key;
  logic             busy, done, key_req, final_round;
  logic [3:0]       key_round;

  logic [127:0] rk_tab [0:15];
  bit           stub;
  int           stall_n, stall_cnt;
  int           pass_cnt, total_cnt;

  aes_round_controller #(.NUM_ROUNDS(NR)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .data_in(data_in),
    .busy(busy), .done(done), .data_out(data_out), .key_req(key_req),
    .key_round(key_round), .key_valid(key_valid), .round_key(round_key),
    .round_in(round_in), .final_round(final_round), .round_out(round_out),
    .rk_state(rk_state), .rk_key(rk_key), .rk_result(rk_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:15][7:0] sub_shift(input logic [0:15][7:0] s);
    logic [0:15][7:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[r + 4*c] = SBOX[s[r + 4*((c + r) % 4)]];
    return o;
  endfunction

  function automatic logic [0:15][7:0] mix_cols(input logic [0:15][7:0] s);
    logic [0:15][7:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
      o[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {RCON[i/4 - 1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Reference round datapath and key schedule responder
  always_comb begin
    if (stub) begin
      round_out = round_in;
      round_key = {4{32'h01010101}};
    end else begin
      round_out = final_round ? sub_shift(round_in) : mix_cols(sub_shift(round_in));
      round_key = rk_tab[key_round];
    end
    rk_result = rk_state ^ rk_key;
    key_valid = key_req && (stall_cnt >= stall_n);
  end

  // Stall counter: holds key_valid low for stall_n cycles before every key
  always @(posedge clk) begin
    if (key_req && !key_valid) stall_cnt <= stall_cnt + 1;
    else                       stall_cnt <= 0;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, done, key_req, final_round, key_round} !== 8'h00) $display("FAIL reset_ctrl: got %b expected 0", {busy, done, key_req, final_round, key_round});
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 128'h0) $display("FAIL reset_data_out: got %h expected 0", data_out);
    else pass_cnt++;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic run_enc(input string name, input bit use_stub, input int stall,
                         input logic [127:0] pt, input logic [127:0] exp,
                         input int pulse_a, input int pulse_b, input bit abort_too);
    int n, idx, extra_done;
    bit seen, idx_ok, fr_ok;
    stub = use_stub; stall_n = stall;
    @(negedge clk);
    data_in = pt; start = 1'b1; abort = abort_too;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    n = 0; idx = 0; seen = 0; idx_ok = 1; fr_ok = 1; extra_done = 0;
    while (!seen && n < 400) begin
      if (key_req) begin
        if (final_round !== (idx == NR)) fr_ok = 0;
        if (key_valid) begin
          if (key_round !== 4'(idx)) idx_ok = 0;
          idx++;
        end
      end
      if (n == pulse_a || n == pulse_b) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (done) seen = 1;
    end
    total_cnt++;
    if (!seen) $display("FAIL %s_done_timeout: got no done expected done", name);
    else pass_cnt++;
    total_cnt++;
    if (n != 11 + 11*stall) $display("FAIL %s_latency: got %0d expected %0d", name, n, 11 + 11*stall);
    else pass_cnt++;
    chk({name, "_data_out"}, data_out, exp);
    total_cnt++;
    if (!idx_ok || idx != NR + 1) $display("FAIL %s_key_round_seq: got %0d keys ok=%0d expected 11 ok=1", name, idx, idx_ok);
    else pass_cnt++;
    total_cnt++;
    if (!fr_ok) $display("FAIL %s_final_round: got mismatched decode expected high only at round 10", name);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra_done++;
    end
    total_cnt++;
    if (extra_done != 0) $display("FAIL %s_idle_after: got %0d busy/done cycles expected 0", name, extra_done);
    else pass_cnt++;
  endtask

  task automatic wait_round(input int r);
    int n;
    n = 0;
    while (key_round !== 4'(r) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    total_cnt++;
    if (n >= 100) $display("FAIL wait_round%0d: got timeout expected round reached", r);
    else pass_cnt++;
  endtask

  task automatic test_idle_abort;
    @(negedge clk); abort = 1'b1;
    repeat (2) @(posedge clk);
    #1; abort = 1'b0;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL idle_abort_busy: got %b expected 0", busy);
    else pass_cnt++;
    chk("idle_abort_data_out", data_out, STUB_CT);
  endtask

  task automatic test_abort;
    int nd;
    stub = 0; stall_n = 0;
    @(negedge clk); data_in = PT; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_round(5);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    total_cnt++;
    if ({busy, key_req, done, key_round} !== 7'b0) $display("FAIL abort_idle: got %b expected 0", {busy, key_req, done, key_round});
    else pass_cnt++;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    total_cnt++;
    if (nd != 0) $display("FAIL abort_no_done: got %0d done pulses expected 0", nd);
    else pass_cnt++;
    chk("abort_data_out_held", data_out, CT);
    run_enc("after_abort", 0, 0, PT, CT, -1, -1, 0);
  endtask

  task automatic test_reset_mid;
    stub = 0; stall_n = 0;
    @(negedge clk); data_in = PT; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_round(6);
    #2 n_rst = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, key_req, final_round, key_round} !== 8'h00) $display("FAIL async_reset_ctrl: got %b expected 0", {busy, done, key_req, final_round, key_round});
    else pass_cnt++;
    chk("async_reset_data_out", data_out, 128'h0);
    chk("async_reset_state", round_in, 128'h0);
    @(negedge clk); n_rst = 1'b1;
    run_enc("after_reset", 0, 0, PT, CT, -1, -1, 0);
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; stub = 0; stall_n = 0;
    expand_key(KEY);
    test_reset;
    run_enc("fips", 0, 0, PT, CT, -1, -1, 0);
    run_enc("stub", 1, 0, 128'h0, STUB_CT, -1, -1, 0);
    test_idle_abort;
    run_enc("stall3", 0, 3, PT, CT, -1, -1, 0);
    run_enc("back_to_back", 0, 0, PT, CT, 3, 7, 0);
    run_enc("start_with_abort", 0, 0, PT, CT, -1, -1, 1);
    test_abort;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
